// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if
//   Bundle of signals between the writeback sources and the register file:
//   - requester side: req_valid/req_ready handshake plus per-request
//     destination address and data, packed 5 and 32 bits per request;
//   - register-file side: registered rd_addr/rd_data/rd_wen write port;
//   - decode side: rs1/rs2 bypass compare inputs, forward flags and data.
//   Modports:
//   - slave: the arbiter view;
//   - master: the view of the requesters and decode that drive it.
interface regfile_wb_arbiter_if #(
   parameter int NUM_REQ = 3
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*5-1:0]  req_rd_addr;
   logic [NUM_REQ*32-1:0] req_rd_data;
   logic [4:0]            rd_addr;
   logic [31:0]           rd_data;
   logic                  rd_wen;
   logic [4:0]            rs1_addr;
   logic [4:0]            rs2_addr;
   logic                  rs1_fwd;
   logic                  rs2_fwd;
   logic [31:0]           fwd_data;

   modport slave (
      input  req_valid, req_rd_addr, req_rd_data, rs1_addr, rs2_addr,
      output req_ready, rd_addr, rd_data, rd_wen, rs1_fwd, rs2_fwd, fwd_data
   );

   modport master (
      output req_valid, req_rd_addr, req_rd_data, rs1_addr, rs2_addr,
      input  req_ready, rd_addr, rd_data, rd_wen, rs1_fwd, rs2_fwd, fwd_data
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Round-robin arbiter sharing the register file's single write port among
//   NUM_REQ (2..4) writeback sources. The winning request is captured in a
//   registered output stage. Decode gets a bypass for the write sitting in
//   that stage. A saturating counter records the number of contended cycles.
//   Ports:
//   - clk: rising-edge clock;
//   - rst_n: synchronous active-low reset;
//   - bus: requester handshake, register-file write port and bypass
//     (slave modport);
//   - contention_cnt: cycles with two or more requests valid; saturating.
module regfile_wb_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   regfile_wb_arbiter_if.slave   bus,
   output logic [CNT_W-1:0]      contention_cnt
);

   localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic               rd_wen_q, rd_wen_d;
   logic [4:0]         rd_addr_q, rd_addr_d;
   logic [31:0]        rd_data_q, rd_data_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               grant_vld;
   logic [PTR_W-1:0]   grant_idx;
   logic [PTR_W-1:0]   scan_idx;
   logic [NUM_REQ-1:0] grant_oh;
   logic [4:0]         grant_addr;
   logic [31:0]        grant_data;
   logic [2:0]         num_valid;
   logic               contended;

   // Index p+k wrapped into 0..NUM_REQ-1 (k is at most NUM_REQ-1).
   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= NUM_REQ) begin
         s = s - NUM_REQ;
      end else begin
         s = s;
      end
      return s[PTR_W-1:0];
   endfunction

   // Round-robin scan starting at rr_ptr; first valid request wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      scan_idx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = wrap_add(rr_ptr_q, k);
         if (!grant_vld && bus.req_valid[scan_idx]) begin
            grant_vld = 1'b1;
            grant_idx = scan_idx;
         end else begin
            grant_vld = grant_vld;
         end
      end
   end

   // One-hot ready, suppressed while reset is asserted so a grant in the
   // reset cycle is never seen by a requester.
   always_comb begin
      grant_oh = '0;
      if (grant_vld && rst_n) begin
         grant_oh[grant_idx] = 1'b1;
      end else begin
         grant_oh = '0;
      end
   end

   // Winner's destination and data, plus the contention popcount.
   always_comb begin
      grant_addr = bus.req_rd_addr[int'(grant_idx)*5 +: 5];
      grant_data = bus.req_rd_data[int'(grant_idx)*32 +: 32];
      num_valid  = 3'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         num_valid = num_valid + {2'd0, bus.req_valid[i]};
      end
      contended = (num_valid >= 3'd2);
   end

   // Next-state: pointer advance, output stage load and counter.
   always_comb begin
      rr_ptr_d  = rr_ptr_q;
      rd_wen_d  = 1'b0;
      rd_addr_d = rd_addr_q;
      rd_data_d = rd_data_q;
      cnt_d     = cnt_q;
      if (grant_vld) begin
         rr_ptr_d  = wrap_add(grant_idx, 1);
         // A write to x0 is consumed but never reaches the register file.
         rd_wen_d  = (grant_addr != 5'd0);
         rd_addr_d = grant_addr;
         rd_data_d = grant_data;
      end else begin
         rd_wen_d  = 1'b0;
      end
      if (contended && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_q  <= '0;
         rd_wen_q  <= 1'b0;
         rd_addr_q <= 5'd0;
         rd_data_q <= 32'd0;
         cnt_q     <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         rd_wen_q  <= rd_wen_d;
         rd_addr_q <= rd_addr_d;
         rd_data_q <= rd_data_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.req_ready   = grant_oh;
   assign bus.rd_wen      = rd_wen_q;
   assign bus.rd_addr     = rd_addr_q;
   assign bus.rd_data     = rd_data_q;
   assign bus.fwd_data    = rd_data_q;
   // The register file commits rd_* at the next edge, so a same-cycle read
   // of that register must take the bypass.
   assign bus.rs1_fwd     = rd_wen_q && (bus.rs1_addr != 5'd0) && (bus.rs1_addr == rd_addr_q);
   assign bus.rs2_fwd     = rd_wen_q && (bus.rs2_addr != 5'd0) && (bus.rs2_addr == rd_addr_q);
   assign contention_cnt  = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

   logic        clk;
   logic        rst_n;
   logic        rst_n_s;
   logic [15:0] cnt_m;
   logic [3:0]  cnt_s;

   regfile_wb_arbiter_if #(.NUM_REQ(3)) bus_m ();
   regfile_wb_arbiter_if #(.NUM_REQ(3)) bus_s ();

   regfile_wb_arbiter #(.NUM_REQ(3), .CNT_W(16)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus_m),
      .contention_cnt (cnt_m)
   );

   regfile_wb_arbiter #(.NUM_REQ(3), .CNT_W(4)) dut_sat (
      .clk            (clk),
      .rst_n          (rst_n_s),
      .bus            (bus_s),
      .contention_cnt (cnt_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic [2:0]  vld;
      logic [4:0]  a0, a1, a2;
      logic [31:0] d0, d1, d2;
      logic [4:0]  rs1, rs2;
      logic [2:0]  rdy;
      logic        f1, f2;
   } vec_t;

   typedef struct {
      logic        wen;
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   vec_t vecs[22];
   wr_t  sb_q[$];
   int   checks;
   int   failures;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      wr_t         e;
      wr_t         nxt;
      logic [15:0] m_cnt;
      logic [4:0]  last_addr;
      logic [31:0] last_data;
      logic [3:0]  s_exp;

      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      rst_n_s  = 1'b0;
      bus_m.req_valid = 3'b000; bus_m.req_rd_addr = 15'd0; bus_m.req_rd_data = 96'd0;
      bus_m.rs1_addr  = 5'd0;   bus_m.rs2_addr    = 5'd0;
      bus_s.req_valid = 3'b000; bus_s.req_rd_addr = 15'd0; bus_s.req_rd_data = 96'd0;
      bus_s.rs1_addr  = 5'd0;   bus_s.rs2_addr    = 5'd0;

      //          rst   vld     a0     a1     a2     d0            d1          d2          rs1    rs2    rdy     f1    f2
      vecs[0]  = '{1'b0, 3'b000, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,      32'h0,      5'd0,  5'd0,  3'b000, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 3'b000, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,      32'h0,      5'd0,  5'd0,  3'b000, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 3'b001, 5'd5,  5'd0,  5'd0,  32'hDEADBEEF, 32'h0,      32'h0,      5'd0,  5'd0,  3'b001, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 3'b000, 5'd5,  5'd0,  5'd0,  32'hDEADBEEF, 32'h0,      32'h0,      5'd5,  5'd0,  3'b000, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 3'b101, 5'd4,  5'd0,  5'd9,  32'h44,       32'h0,      32'h99,     5'd0,  5'd0,  3'b100, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 3'b111, 5'd4,  5'd2,  5'd3,  32'h44,       32'h22,     32'h33,     5'd0,  5'd0,  3'b001, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 3'b111, 5'd4,  5'd2,  5'd3,  32'h44,       32'h22,     32'h33,     5'd4,  5'd2,  3'b010, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 3'b111, 5'd4,  5'd2,  5'd3,  32'h44,       32'h22,     32'h33,     5'd0,  5'd0,  3'b100, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 3'b111, 5'd4,  5'd2,  5'd3,  32'h44,       32'h22,     32'h33,     5'd0,  5'd0,  3'b001, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 3'b111, 5'd4,  5'd2,  5'd3,  32'h44,       32'h22,     32'h33,     5'd0,  5'd0,  3'b010, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 3'b111, 5'd4,  5'd2,  5'd3,  32'h44,       32'h22,     32'h33,     5'd0,  5'd0,  3'b100, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 3'b010, 5'd4,  5'd0,  5'd3,  32'h44,       32'h1234,   32'h33,     5'd0,  5'd3,  3'b010, 1'b0, 1'b1};
      vecs[12] = '{1'b1, 3'b000, 5'd4,  5'd0,  5'd3,  32'h44,       32'h1234,   32'h33,     5'd0,  5'd0,  3'b000, 1'b0, 1'b0};
      vecs[13] = '{1'b1, 3'b001, 5'd7,  5'd0,  5'd3,  32'hA5A5A5A5, 32'h0,      32'h33,     5'd0,  5'd0,  3'b001, 1'b0, 1'b0};
      vecs[14] = '{1'b1, 3'b000, 5'd7,  5'd0,  5'd3,  32'hA5A5A5A5, 32'h0,      32'h33,     5'd7,  5'd8,  3'b000, 1'b1, 1'b0};
      vecs[15] = '{1'b1, 3'b000, 5'd7,  5'd0,  5'd3,  32'hA5A5A5A5, 32'h0,      32'h33,     5'd7,  5'd8,  3'b000, 1'b0, 1'b0};
      vecs[16] = '{1'b1, 3'b001, 5'd1,  5'd0,  5'd2,  32'h100,      32'h0,      32'h200,    5'd0,  5'd0,  3'b001, 1'b0, 1'b0};
      vecs[17] = '{1'b0, 3'b101, 5'd1,  5'd0,  5'd2,  32'h100,      32'h0,      32'h200,    5'd0,  5'd0,  3'b000, 1'b0, 1'b0};
      vecs[18] = '{1'b1, 3'b101, 5'd1,  5'd0,  5'd2,  32'h100,      32'h0,      32'h200,    5'd0,  5'd0,  3'b001, 1'b0, 1'b0};
      vecs[19] = '{1'b1, 3'b100, 5'd1,  5'd0,  5'd2,  32'h100,      32'h0,      32'h200,    5'd1,  5'd1,  3'b100, 1'b1, 1'b1};
      vecs[20] = '{1'b1, 3'b000, 5'd1,  5'd0,  5'd2,  32'h100,      32'h0,      32'h200,    5'd2,  5'd0,  3'b000, 1'b1, 1'b0};
      vecs[21] = '{1'b1, 3'b000, 5'd1,  5'd0,  5'd2,  32'h100,      32'h0,      32'h200,    5'd0,  5'd0,  3'b000, 1'b0, 1'b0};

      // The first edge at t=5 sees rst_n low, so the stage starts cleared.
      m_cnt     = 16'd0;
      last_addr = 5'd0;
      last_data = 32'd0;
      sb_q.push_back('{1'b0, 5'd0, 32'd0});

      for (int r = 0; r < 22; r++) begin
         @(negedge clk);
         rst_n              = vecs[r].rst_n;
         bus_m.req_valid    = vecs[r].vld;
         bus_m.req_rd_addr  = {vecs[r].a2, vecs[r].a1, vecs[r].a0};
         bus_m.req_rd_data  = {vecs[r].d2, vecs[r].d1, vecs[r].d0};
         bus_m.rs1_addr     = vecs[r].rs1;
         bus_m.rs2_addr     = vecs[r].rs2;
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk($sformatf("row%0d_rd_wen", r),   {31'd0, bus_m.rd_wen}, {31'd0, e.wen});
            chk($sformatf("row%0d_rd_addr", r),  {27'd0, bus_m.rd_addr}, {27'd0, e.addr});
            chk($sformatf("row%0d_rd_data", r),  bus_m.rd_data, e.data);
            chk($sformatf("row%0d_fwd_data", r), bus_m.fwd_data, e.data);
         end
         chk($sformatf("row%0d_req_ready", r), {29'd0, bus_m.req_ready}, {29'd0, vecs[r].rdy});
         chk($sformatf("row%0d_rs1_fwd", r),   {31'd0, bus_m.rs1_fwd}, {31'd0, vecs[r].f1});
         chk($sformatf("row%0d_rs2_fwd", r),   {31'd0, bus_m.rs2_fwd}, {31'd0, vecs[r].f2});
         chk($sformatf("row%0d_cnt", r),       {16'd0, cnt_m}, {16'd0, m_cnt});

         // Expected output stage after this edge, derived from the expected grant.
         if (!vecs[r].rst_n) begin
            nxt = '{1'b0, 5'd0, 32'd0};
            m_cnt = 16'd0;
         end else begin
            case (vecs[r].rdy)
               3'b001:  nxt = '{(vecs[r].a0 != 5'd0), vecs[r].a0, vecs[r].d0};
               3'b010:  nxt = '{(vecs[r].a1 != 5'd0), vecs[r].a1, vecs[r].d1};
               3'b100:  nxt = '{(vecs[r].a2 != 5'd0), vecs[r].a2, vecs[r].d2};
               default: nxt = '{1'b0, last_addr, last_data};
            endcase
            if (($countones(vecs[r].vld) >= 2) && (m_cnt != 16'hFFFF)) begin
               m_cnt = m_cnt + 16'd1;
            end
         end
         last_addr = nxt.addr;
         last_data = nxt.data;
         sb_q.push_back(nxt);
      end

      // Flush the last expected write.
      @(negedge clk);
      bus_m.req_valid = 3'b000;
      #1;
      e = sb_q.pop_front();
      chk("flush_rd_wen",  {31'd0, bus_m.rd_wen}, {31'd0, e.wen});
      chk("flush_rd_data", bus_m.rd_data, e.data);

      // Saturation: 4-bit counter with two requests valid for 20 cycles.
      @(negedge clk);
      #1;
      chk("sat_reset_cnt", {28'd0, cnt_s}, 32'd0);
      s_exp = 4'd0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         rst_n_s         = 1'b1;
         bus_s.req_valid = 3'b011;
         #1;
         chk($sformatf("sat_cnt_c%0d", c), {28'd0, cnt_s}, {28'd0, s_exp});
         if (s_exp != 4'hF) s_exp = s_exp + 4'd1;
      end
      @(negedge clk);
      bus_s.req_valid = 3'b000;
      #1;
      chk("sat_cnt_final", {28'd0, cnt_s}, 32'd15);
      @(negedge clk);
      #1;
      chk("sat_cnt_hold", {28'd0, cnt_s}, 32'd15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
